// File: rtl/nina_uart_rx.sv
// UART receiver for the NINA module link: 2-flop synchronized RX line, mid-bit
// sampling FSM, optional parity, small receive FIFO and sticky error flags.
module nina_uart_rx #(
  parameter int CLKS_PER_BIT = 1042,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                          iCLK,
  input  logic                          iRESETn,
  input  logic                          iRX,
  output logic [7:0]                    oDATA,
  output logic                          oVALID,
  input  logic                          iREADY,
  output logic [$clog2(FIFO_DEPTH):0]   oLEVEL,
  output logic                          oFRAME_ERR,
  output logic                          oPARITY_ERR,
  output logic                          oOVERRUN,
  input  logic                          iCLR_ERR
);

  // state     | meaning
  // ----------+-----------------------------------------------------
  // IDLE      | line high, waiting for a falling edge
  // START     | half-bit wait, confirm start bit still low at centre
  // DATA      | sample 8 data bits, LSB first, at each bit centre
  // PARITY    | sample parity bit and judge it against the data
  // STOP      | sample stop bit, push / discard / flag the frame
  // WAIT_HIGH | framing error seen, wait for line to return high

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
  localparam logic          ODD_PAR  = (PARITY_ODD != 0);
  localparam logic          HAS_PAR  = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_t;

  logic          r_rx_meta;
  logic          r_rx_sync;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_par_bad;

  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [2:0]    w_bit_idx_nxt;
  logic [7:0]    w_shift_nxt;
  logic          w_par_bad_nxt;
  logic          w_push;
  logic          w_set_frame;
  logic          w_set_parity;
  logic          w_tick;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_frame_err;
  logic          r_parity_err;
  logic          r_overrun;

  logic          w_full;
  logic          w_pop;
  logic          w_wr;
  logic          w_set_overrun;

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= iRX;
      r_rx_sync <= r_rx_meta;
    end
  end

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_par_bad <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_par_bad <= w_par_bad_nxt;
    end
  end

  assign w_tick = (r_cnt == '0);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_par_bad_nxt = r_par_bad;
    w_push        = 1'b0;
    w_set_frame   = 1'b0;
    w_set_parity  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!r_rx_sync) begin
          w_state_nxt   = S_START;
          w_cnt_nxt     = HALF_BIT;
          w_bit_idx_nxt = '0;
          w_par_bad_nxt = 1'b0;
        end
      end
      S_START: begin
        if (!w_tick) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else if (!r_rx_sync) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = FULL_BIT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DATA: begin
        if (!w_tick) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_shift_nxt   = {r_rx_sync, r_shift[7:1]};
          w_cnt_nxt     = FULL_BIT;
          w_bit_idx_nxt = r_bit_idx + 1'b1;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = HAS_PAR ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (!w_tick) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          // XOR over data plus parity bit must equal 0 (even) or 1 (odd)
          w_par_bad_nxt = ((^r_shift) ^ r_rx_sync) != ODD_PAR;
          w_cnt_nxt     = FULL_BIT;
          w_state_nxt   = S_STOP;
        end
      end
      S_STOP: begin
        if (!w_tick) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else if (r_rx_sync) begin
          w_push       = !r_par_bad;
          w_set_parity = r_par_bad;
          w_state_nxt  = S_IDLE;
        end else begin
          w_set_frame = 1'b1;
          w_state_nxt = S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        if (r_rx_sync) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_full        = (r_level == LVL_FULL);
  assign w_pop         = (r_level != '0) && iREADY;
  // a simultaneous pop frees the slot, so a push into a full FIFO still lands
  assign w_wr          = w_push && (!w_full || w_pop);
  assign w_set_overrun = w_push && w_full && !w_pop;

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= r_shift;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_err  <= w_set_frame   || (r_frame_err  && !iCLR_ERR);
      r_parity_err <= w_set_parity  || (r_parity_err && !iCLR_ERR);
      r_overrun    <= w_set_overrun || (r_overrun    && !iCLR_ERR);
    end
  end

  assign oDATA       = r_mem[r_rd_ptr];
  assign oVALID      = (r_level != '0);
  assign oLEVEL      = r_level;
  assign oFRAME_ERR  = r_frame_err;
  assign oPARITY_ERR = r_parity_err;
  assign oOVERRUN    = r_overrun;

endmodule

// File: doc/nina_uart_rx.md
NINA_UART_RX -- requirements
Module: nina_uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1042, iCLK cycles per serial bit (120 MHz / 115200); legal range >= 4.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries; power of two, >= 2.
REQ-003 SHALL have parameter PARITY_EN, default 0, 1 = parity bit expected between data and stop.
REQ-004 SHALL have parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.
REQ-005 SHALL have port iCLK, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port iRESETn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port iRX, input, 1, asynchronous serial line from NINA TX; idle high.
REQ-008 SHALL have port oDATA, output, 8, byte at FIFO head.
REQ-009 SHALL have port oVALID, output, 1, FIFO non-empty.
REQ-010 SHALL have port iREADY, input, 1, consumer accepts oDATA.
REQ-011 SHALL have port oLEVEL, output, clog2(FIFO_DEPTH)+1, FIFO occupancy.
REQ-012 SHALL have port oFRAME_ERR, output, 1, sticky framing error.
REQ-013 SHALL have port oPARITY_ERR, output, 1, sticky parity error.
REQ-014 SHALL have port oOVERRUN, output, 1, sticky overrun.
REQ-015 SHALL have port iCLR_ERR, input, 1, synchronous clear of all sticky flags.

Function
REQ-016 SHALL pass iRX through a 2-flop synchronizer; sync flops reset to 1; all decisions use the synchronized value.
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-018 IDLE: synchronized line = 0 -> START; bit counter loaded with CLKS_PER_BIT/2 - 1.
REQ-019 START: at counter zero (mid start bit), line = 0 -> DATA with counter CLKS_PER_BIT - 1; line = 1 -> IDLE (glitch rejected, no flag).
REQ-020 DATA: sample every CLKS_PER_BIT cycles at bit centre, LSB first, exactly 8 bits; then PARITY if PARITY_EN, else STOP.
REQ-021 PARITY: sample one bit; mismatch vs. even/odd parity of the 8 data bits marks the frame bad-parity.
REQ-022 STOP: sample stop bit; 1 with good parity -> push byte to FIFO, -> IDLE; 1 with bad parity -> byte discarded, oPARITY_ERR set, -> IDLE; 0 -> byte discarded, oFRAME_ERR set, -> WAIT_HIGH.
REQ-023 WAIT_HIGH: remain until synchronized line = 1, then -> IDLE (break never re-triggers a start).
REQ-024 Push latency: oVALID/oLEVEL reflect pushed byte the cycle after the stop-bit sample cycle.
REQ-025 Pop occurs on a cycle with oVALID = 1 and iREADY = 1; oDATA advances next cycle; iREADY ignored when empty.
REQ-026 Push when FIFO full and no pop in same cycle: byte dropped, FIFO unchanged, oOVERRUN set.
REQ-027 Push and pop in same cycle: both take effect; oLEVEL unchanged; legal when full (no overrun).
REQ-028 Pointers wrap modulo FIFO_DEPTH; oLEVEL ranges 0..FIFO_DEPTH.
REQ-029 iCLR_ERR clears all sticky flags next cycle; if a flag's set event coincides with iCLR_ERR, set wins.
REQ-030 oDATA SHALL be stable while oVALID = 1 and no pop occurs.

Reset
REQ-031 iRESETn low SHALL immediately force state IDLE, counters 0, FIFO empty, oVALID 0, oLEVEL 0, oDATA 0x00, all flags 0, sync flops 1.
REQ-032 Reset asserted mid-frame SHALL discard the partial byte; after release, reception resumes at the next falling edge on iRX.

Verification (CLKS_PER_BIT = 16, FIFO_DEPTH = 4)
REQ-033 Frame 0x55, 8N1, iREADY = 1 -> oDATA = 0x55, oVALID high exactly one cycle, all flags 0.
REQ-034 iRX low for 4 cycles, then high -> no push, oLEVEL stays 0, no flags set.
REQ-035 Frame 0xA3 with stop bit 0, line held low 40 cycles, then frame 0x12 -> oFRAME_ERR = 1, only 0x12 received.
REQ-036 iREADY = 0, frames 0x01..0x05 -> oLEVEL = 4, oOVERRUN = 1; then iREADY = 1 -> pops 0x01..0x04 in order, then oVALID = 0.
REQ-037 PARITY_EN = 1, even; 0x07 with parity 0 -> oPARITY_ERR = 1, no push; 0x07 with parity 1 -> push 0x07; iCLR_ERR pulse -> flag 0.
REQ-038 iRESETn pulsed low during DATA bit 4 -> outputs at reset values; next full frame 0xC3 received correctly.
